// File: rtl/sync_fifo_param.sv
// Purpose : parametrised single-clock FIFO with occupancy count, almost-full/empty
//           thresholds, overflow/underflow pulses and registered or fall-through read.
// Latency : write visible in count/flags one edge later; FWFT=0 read data one edge
//           after rd_en_i, FWFT=1 head word shown combinationally while not empty.
// Backpressure: none upstream; a write when full (without a same-cycle read) or a read
//           when empty is dropped and reported by a one-cycle overflow/underflow pulse.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset (pointers, count, pulses, read reg)
//   wr_en_i        write request, wdata_i stored when accepted
//   wdata_i        write data
//   rd_en_i        read request (FWFT=1: pop/acknowledge of the displayed word)
//   rdata_o        read data
//   full_o         count == DEPTH
//   empty_o        count == 0
//   almost_full_o  count >= AF_LEVEL
//   almost_empty_o count <= AE_LEVEL
//   count_o        current occupancy
//   overflow_o     registered pulse: a write was rejected
//   underflow_o    registered pulse: a read was rejected
//   error_o        overflow_o | underflow_o
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             error_o
);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_empty;

  assign w_empty  = (r_count == '0);
  // A read never becomes legal because of a same-cycle write into an empty FIFO.
  assign w_rd_acc = rd_en_i && !w_empty;
  // When full, a write is still taken if the slot is freed by a read this cycle.
  assign w_wr_acc = wr_en_i && ((r_count < FULL_CNT) || w_rd_acc);

  // Explicit wrap compare so non-power-of-two depths cycle through 0..DEPTH-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en_i && !w_wr_acc;
      r_underflow <= rd_en_i && !w_rd_acc;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word shown directly; forced to zero while empty so never-written
      // entries cannot leak out right after reset.
      assign rdata_o = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_rdata;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_rdata <= '0;
        end else if (w_rd_acc) begin
          r_rdata <= r_mem[r_rd_ptr];
        end
      end
      assign rdata_o = r_rdata;
    end
  endgenerate

  assign count_o        = r_count;
  assign full_o         = (r_count == FULL_CNT);
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_count >= AF_CNT);
  assign almost_empty_o = (r_count <= AE_CNT);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;
  assign error_o        = r_overflow | r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Purpose : scoreboard bench for sync_fifo_param (default, DEPTH=5, FWFT=1 instances).
// Latency : expected words queued at write time, popped by per-instance monitors.
// Backpressure: directed stimulus exercises overflow/underflow corners explicitly.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- instance A: defaults, registered read ----------------
  logic       a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
  logic [7:0] a_wd = '0, a_rdat;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf, a_err;
  logic [4:0] a_cnt;

  sync_fifo_param u_a (
    .clk_i(clk), .rst_i(a_rst), .wr_en_i(a_wr), .wdata_i(a_wd), .rd_en_i(a_rd),
    .rdata_o(a_rdat), .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af),
    .almost_empty_o(a_ae), .count_o(a_cnt), .overflow_o(a_ovf),
    .underflow_o(a_udf), .error_o(a_err)
  );

  // ---------------- instance B: DEPTH=5, registered read ----------------
  logic       b_rst = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
  logic [7:0] b_wd = '0, b_rdat;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf, b_err;
  logic [2:0] b_cnt;

  sync_fifo_param #(.DEPTH(5)) u_b (
    .clk_i(clk), .rst_i(b_rst), .wr_en_i(b_wr), .wdata_i(b_wd), .rd_en_i(b_rd),
    .rdata_o(b_rdat), .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af),
    .almost_empty_o(b_ae), .count_o(b_cnt), .overflow_o(b_ovf),
    .underflow_o(b_udf), .error_o(b_err)
  );

  // ---------------- instance C: defaults, fall-through ----------------
  logic       c_rst = 1'b1, c_wr = 1'b0, c_rd = 1'b0;
  logic [7:0] c_wd = '0, c_rdat;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_udf, c_err;
  logic [4:0] c_cnt;

  sync_fifo_param #(.FWFT(1'b1)) u_c (
    .clk_i(clk), .rst_i(c_rst), .wr_en_i(c_wr), .wdata_i(c_wd), .rd_en_i(c_rd),
    .rdata_o(c_rdat), .full_o(c_full), .empty_o(c_empty), .almost_full_o(c_af),
    .almost_empty_o(c_ae), .count_o(c_cnt), .overflow_o(c_ovf),
    .underflow_o(c_udf), .error_o(c_err)
  );

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  // Monitors run on the falling edge: inputs for the next rising edge are stable
  // and outputs reflect the previous rising edge.
  logic a_pend = 1'b0;
  logic b_pend = 1'b0;

  always @(negedge clk) begin
    if (a_pend) begin
      if (qa.size() == 0) chk("A scoreboard underrun", 32'd1, 32'd0);
      else chk("A rdata order", a_rdat, qa.pop_front());
    end
    a_pend = !a_rst && a_rd && !a_empty;
  end

  always @(negedge clk) begin
    if (b_pend) begin
      if (qb.size() == 0) chk("B scoreboard underrun", 32'd1, 32'd0);
      else chk("B rdata order", b_rdat, qb.pop_front());
    end
    b_pend = !b_rst && b_rd && !b_empty;
  end

  // Fall-through: the displayed word is what gets popped on this edge.
  always @(negedge clk) begin
    if (!c_rst && c_rd && !c_empty) begin
      if (qc.size() == 0) chk("C scoreboard underrun", 32'd1, 32'd0);
      else chk("C rdata head", c_rdat, qc.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic wr, input logic [7:0] d, input logic rd);
    a_wr = wr; a_wd = d; a_rd = rd;
    tick();
  endtask

  task automatic c_drive(input logic wr, input logic [7:0] d, input logic rd);
    c_wr = wr; c_wd = d; c_rd = rd;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bm;
    int wn;
    logic bw, br, bra, bwa;

    // ---------------- reset ----------------
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();
    chk("A reset count", a_cnt, 32'd0);
    chk("A reset empty", a_empty, 32'd1);
    chk("A reset full", a_full, 32'd0);
    chk("A reset almost_empty", a_ae, 32'd1);
    chk("A reset almost_full", a_af, 32'd0);
    chk("A reset error", a_err, 32'd0);
    chk("A reset rdata", a_rdat, 32'd0);

    // ---------------- fill 0x01..0x10 ----------------
    for (int i = 1; i <= 16; i++) begin
      a_drive(1'b1, 8'(i), 1'b0);
      qa.push_back(8'(i));
      chk("A fill count", a_cnt, i);
      chk("A fill almost_full", a_af, (i >= 14) ? 1 : 0);
      chk("A fill full", a_full, (i == 16) ? 1 : 0);
    end
    a_drive(1'b1, 8'h99, 1'b0);
    chk("A overflow pulse", a_ovf, 32'd1);
    chk("A overflow error", a_err, 32'd1);
    chk("A overflow count held", a_cnt, 32'd16);
    a_drive(1'b0, 8'h00, 1'b0);
    chk("A overflow one cycle", a_ovf, 32'd0);

    // ---------------- drain, then underflow ----------------
    for (int i = 1; i <= 16; i++) begin
      a_drive(1'b0, 8'h00, 1'b1);
      chk("A drain count", a_cnt, 16 - i);
      chk("A drain almost_empty", a_ae, ((16 - i) <= 2) ? 1 : 0);
      chk("A drain empty", a_empty, (i == 16) ? 1 : 0);
    end
    a_drive(1'b0, 8'h00, 1'b1);
    chk("A underflow pulse", a_udf, 32'd1);
    chk("A underflow error", a_err, 32'd1);
    chk("A underflow rdata held", a_rdat, 32'h10);
    a_drive(1'b0, 8'h00, 1'b0);
    chk("A underflow one cycle", a_udf, 32'd0);

    // ---------------- simultaneous R/W at empty ----------------
    a_drive(1'b1, 8'h55, 1'b1);
    qa.push_back(8'h55);
    chk("A rw@empty underflow", a_udf, 32'd1);
    chk("A rw@empty count", a_cnt, 32'd1);

    // refill to 16 with 0xB1..0xBF
    for (int i = 1; i <= 15; i++) begin
      a_drive(1'b1, 8'hB0 + 8'(i), 1'b0);
      qa.push_back(8'hB0 + 8'(i));
    end
    chk("A refill full", a_full, 32'd1);

    // ---------------- simultaneous R/W at full ----------------
    a_drive(1'b1, 8'hAA, 1'b1);
    qa.push_back(8'hAA);
    chk("A rw@full no overflow", a_ovf, 32'd0);
    chk("A rw@full count", a_cnt, 32'd16);
    for (int i = 1; i <= 16; i++) a_drive(1'b0, 8'h00, 1'b1);
    a_drive(1'b0, 8'h00, 1'b0);
    chk("A 0xAA returned last", a_rdat, 32'hAA);
    chk("A scoreboard drained", qa.size(), 32'd0);

    // ---------------- reset mid-stream ----------------
    for (int i = 1; i <= 7; i++) begin
      a_drive(1'b1, 8'h70 + 8'(i), 1'b0);
      qa.push_back(8'h70 + 8'(i));
    end
    chk("A pre-reset count", a_cnt, 32'd7);
    a_rst = 1'b1;
    qa.delete();
    a_drive(1'b1, 8'hEE, 1'b1);
    a_rst = 1'b0;
    chk("A midrst count", a_cnt, 32'd0);
    chk("A midrst empty", a_empty, 32'd1);
    chk("A midrst no overflow", a_ovf, 32'd0);
    chk("A midrst no underflow", a_udf, 32'd0);
    a_drive(1'b0, 8'h00, 1'b0);
    chk("A post-rst error", a_err, 32'd0);

    // ---------------- DEPTH=5 stream with wrap ----------------
    bm = 0;
    wn = 0;
    for (int c = 0; c < 200; c++) begin
      if (wn == 20 && bm == 0) break;
      bw  = (wn < 20) && ((c % 3) != 2);
      br  = ((c % 2) == 1) || (wn == 20);
      bra = br && (bm > 0);
      bwa = bw && ((bm < 5) || bra);
      b_wr = bw; b_wd = 8'h30 + 8'(wn); b_rd = br;
      if (bwa) begin
        qb.push_back(8'h30 + 8'(wn));
        wn++;
      end
      if (bwa && !bra) bm++;
      else if (bra && !bwa) bm--;
      tick();
      chk("B count", b_cnt, bm);
      chk("B count bound", (b_cnt <= 3'd5) ? 1 : 0, 32'd1);
      chk("B full", b_full, (bm == 5) ? 1 : 0);
      chk("B overflow", b_ovf, (bw && !bwa) ? 1 : 0);
    end
    b_wr = 1'b0; b_rd = 1'b0;
    tick(); tick();
    chk("B all words written", wn, 32'd20);
    chk("B scoreboard drained", qb.size(), 32'd0);

    // ---------------- FWFT ----------------
    c_drive(1'b1, 8'h3C, 1'b0);
    qc.push_back(8'h3C);
    c_drive(1'b0, 8'h00, 1'b0);
    chk("C fwft not empty", c_empty, 32'd0);
    chk("C fwft rdata shown", c_rdat, 32'h3C);
    c_drive(1'b0, 8'h00, 1'b1);
    chk("C fwft empty after pop", c_empty, 32'd1);
    c_drive(1'b1, 8'h11, 1'b0);
    qc.push_back(8'h11);
    c_drive(1'b1, 8'h22, 1'b1);
    qc.push_back(8'h22);
    chk("C fwft next word", c_rdat, 32'h22);
    chk("C fwft count", c_cnt, 32'd1);
    c_drive(1'b0, 8'h00, 1'b1);
    c_drive(1'b0, 8'h00, 1'b1);
    chk("C fwft underflow", c_udf, 32'd1);
    c_drive(1'b0, 8'h00, 1'b0);
    chk("C scoreboard drained", qc.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, successor to the team's fixed 16x8 FIFO. It adds:
- arbitrary (non-power-of-two) depth;
- an occupancy count output;
- programmable almost-full and almost-empty thresholds;
- separate overflow and underflow pulses;
- a choice between registered-read and first-word-fall-through (FWFT) output.

It sits between producer and consumer blocks in the same clock domain, as a rate-smoothing buffer.

## Interface
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 16: number of storage entries (>=2, any integer).
- AF_LEVEL, DEPTH-2: almost_full_o asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty_o asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.
- Derived: PW = clog2(DEPTH) pointer width; CW = clog2(DEPTH+1) count width.
- clk_i  input  1  single clock; everything samples on the rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- wr_en_i  input  1  write request.
- wdata_i  input  WIDTH  write data.
- rd_en_i  input  1  read (pop) request.
- rdata_o  output  WIDTH  read data.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.
- almost_full_o  output  1  count >= AF_LEVEL.
- almost_empty_o  output  1  count <= AE_LEVEL.
- count_o  output  CW  current occupancy.
- overflow_o  output  1  one-cycle pulse: a write was rejected.
- underflow_o  output  1  one-cycle pulse: a read was rejected.
- error_o  output  1  overflow_o | underflow_o.

## Operation
- **State.** State is held in three registers:
  - write pointer wr_ptr (PW bits);
  - read pointer rd_ptr (PW bits);
  - occupancy count (CW bits).
- **Flags.** full_o, empty_o, almost_full_o and almost_empty_o decode combinationally from the count register only, never from pointer comparison.
- **Pointer wrap.** Each pointer advances by 1 per accepted operation. At DEPTH-1 it wraps to 0. This is an explicit compare, so non-power-of-two depths work.
- **Write acceptance.** A write is accepted when wr_en_i=1 and either:
  - count < DEPTH, or
  - count == DEPTH and a read is accepted in the same cycle.
  
  An accepted write stores wdata_i at mem[wr_ptr].
- **Read acceptance.** A read is accepted when rd_en_i=1 and count > 0. A write in the same cycle does not make a read from an empty FIFO legal.
- **Count update per edge.** +1 for write only, -1 for read only, unchanged for both or neither.
- **Rejected write.** Memory, wr_ptr and count are unchanged. overflow_o pulses high for one cycle.
- **Rejected read.** rd_ptr, count and rdata_o are unchanged. underflow_o pulses high for one cycle.
  - If a write is rejected and a read is rejected in the same cycle, both pulses assert.
- **FWFT=0 (registered read).** On an accepted read, rdata_o <= mem[rd_ptr] at the edge. Otherwise rdata_o holds its value.
- **FWFT=1 (fall-through).** rdata_o = mem[rd_ptr] combinationally.
  - The value is valid whenever empty_o=0; it is don't-care when empty.
  - rd_en_i acts as a pop/acknowledge of the displayed word.
- **Storage.** Memory contents are not cleared by reset. No output may expose memory contents that were never written.

## Timing
- **Reset.** While rst_i=1 at a clock edge, the following are 0: wr_ptr, rd_ptr, count, overflow_o, underflow_o, and the rdata_o register.
- **Output values after reset:**
  - empty_o=1, full_o=0, count_o=0;
  - almost_empty_o=1 (AE_LEVEL >= 0);
  - almost_full_o=0;
  - error_o=0.
- **Reset priority.** Reset overrides wr_en_i and rd_en_i in the same cycle. Reset mid-operation discards all contents.
- **Write latency.** count_o and the flags reflect a write one edge after it is sampled.
  - FWFT=1: the first word written into an empty FIFO appears on rdata_o in the cycle after the write edge.
- **Read latency.**
  - FWFT=0: data appears on rdata_o one cycle after the rd_en_i edge.
  - FWFT=1: the next word appears immediately after the pop edge.
- **Pulse timing.** overflow_o and underflow_o are registered. Each is high for exactly the one cycle following the rejecting edge.
- **Throughput.** One write and one read per cycle, sustained, at any occupancy from 1 to DEPTH.

## Test plan
- **Reset, then fill, then overflow.** Reset, then write 0x01..0x10 on 16 consecutive cycles (defaults).
  - count_o steps 1..16.
  - almost_full_o rises when count_o reaches 14.
  - full_o rises after the 16th write.
  - A 17th write gives overflow_o=1 and error_o=1 for one cycle, with count_o staying 16.
- **Drain in order, then underflow.** From full, with FWFT=0, read 16 times.
  - rdata_o returns 0x01..0x10 in order, each one cycle after its rd_en_i.
  - almost_empty_o rises at count 2; empty_o rises at count 0.
  - A 17th read gives underflow_o for one cycle, and rdata_o holds 0x10.
- **Simultaneous read and write.**
  - At count 16: write 0xAA and read together. No overflow; count stays 16; 0xAA is returned last.
  - At count 0: same stimulus gives underflow_o=1 with count going 0→1.
- **Non-power-of-two wrap.** DEPTH=5: stream 20 words with interleaved reads.
  - Pointers wrap at 4→0.
  - Data order is preserved and count_o never exceeds 5.
- **FWFT mode.** FWFT=1: write 0x3C into an empty FIFO.
  - On the next cycle empty_o=0 and rdata_o=0x3C with no rd_en_i.
  - After the rd_en_i pulse, empty_o=1.
- **Reset mid-stream.** Write 7 words, then assert rst_i together with wr_en_i and rd_en_i.
  - Next cycle: count_o=0, empty_o=1, and no overflow or underflow pulse.
